// File: rtl/drift_request_scheduler_pkg.sv
// Shared types for the drift request scheduler: direction, grant source and FSM state encodings.
// The CANCEL state exists only when CLKS_ALOT_DRIFT_CANCEL_EN is defined.
package drift_request_scheduler_pkg;

    localparam int DRIFT_COUNTER_WIDTH = 8;

    typedef enum logic {
        DRIFT_DIR_A = 1'b0,
        DRIFT_DIR_B = 1'b1
    } drift_direction_e;

    typedef enum logic {
        EXPECTED   = 1'b0,
        PREEMPTIVE = 1'b1
    } drift_src_e;

`ifdef CLKS_ALOT_DRIFT_CANCEL_EN
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_ACK     = 3'd2,
        ST_LOCKOUT = 3'd3,
        ST_CANCEL  = 3'd4
    } drift_sched_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_ACK     = 3'd2,
        ST_LOCKOUT = 3'd3
    } drift_sched_state_e;
`endif

endpackage

// File: rtl/drift_request_scheduler_lockout.sv
// drift_lockout_timer: down-counter loaded on lockout entry; done when it reaches 1.
// A clear aborts the count immediately.
module drift_lockout_timer
    import drift_request_scheduler_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_load,
    input  logic                           i_abort,
    input  logic [DRIFT_COUNTER_WIDTH-1:0] i_load_val,
    output logic                           o_done
);

    logic [DRIFT_COUNTER_WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_abort) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - DRIFT_COUNTER_WIDTH'(1);
        end
    end

    assign o_done = (r_count == DRIFT_COUNTER_WIDTH'(1));

endmodule

// File: rtl/drift_request_scheduler.sv
// drift_request_scheduler: round-robin sharing of the clock generator phase-adjust port between
// the expected and preemptive drift requesters. Optional feature macro: CLKS_ALOT_DRIFT_CANCEL_EN.
module drift_request_scheduler
    import drift_request_scheduler_pkg::*;
#(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           scheduler_en_i,
    input  logic                           clear_state_i,
    input  logic [DRIFT_COUNTER_WIDTH-1:0] lockout_duration_i,
    input  logic                           expected_req_i,
    output logic                           expected_res_o,
    input  logic                           expected_dir_i,
    input  logic                           preemptive_req_i,
    output logic                           preemptive_res_o,
    input  logic                           preemptive_dir_i,
    output logic                           adjust_req_o,
    input  logic                           adjust_res_i,
    output logic                           adjust_dir_o,
    output logic                           adjust_src_o,
    output logic                           busy_o,
    output logic                           cancel_o,
    output logic [COUNT_WIDTH-1:0]         adjust_count_o
);

    // state   | meaning
    // IDLE    | no transaction; arbitrate pending requests
    // ISSUE   | adjust_req_o high, waiting for the generator ack
    // ACK     | one-cycle res pulse to the granted requester
    // LOCKOUT | enforced idle time after an applied adjustment
    // CANCEL  | opposite-direction pair answered without adjusting

    drift_sched_state_e     r_state, w_next;
    drift_src_e             r_ptr, r_src, w_grant_src;
    drift_direction_e       r_dir;
    logic                   r_adjust_req, r_expected_res, r_preemptive_res, r_busy, r_clr_pend;
    logic [COUNT_WIDTH-1:0] r_count;
    logic w_both, w_conflict, w_clr_issue, w_soft_clear;
    logic w_exp_res_nxt, w_pre_res_nxt;
    logic w_lock_load, w_lock_abort, w_lock_done;

    assign w_both = expected_req_i & preemptive_req_i;
`ifdef CLKS_ALOT_DRIFT_CANCEL_EN
    assign w_conflict = w_both & (expected_dir_i != preemptive_dir_i);
`else
    assign w_conflict = 1'b0;
`endif
    assign w_grant_src  = w_both ? r_ptr : (preemptive_req_i ? PREEMPTIVE : EXPECTED);
    assign w_clr_issue  = r_clr_pend | clear_state_i;
    // The generator handshake is never abandoned, so a clear during ISSUE lands on the ack.
    assign w_soft_clear = (clear_state_i && (r_state != ST_ISSUE)) ||
                          ((r_state == ST_ISSUE) && adjust_res_i && w_clr_issue);
    assign w_lock_load  = (r_state == ST_ACK) && (w_next == ST_LOCKOUT);
    assign w_lock_abort = clear_state_i && (r_state != ST_ISSUE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (scheduler_en_i && !clear_state_i && (expected_req_i || preemptive_req_i)) begin
                    if (w_conflict) begin
`ifdef CLKS_ALOT_DRIFT_CANCEL_EN
                        w_next = ST_CANCEL;
`endif
                    end else begin
                        w_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE:   if (adjust_res_i) w_next = w_clr_issue ? ST_IDLE : ST_ACK;
            ST_ACK:     w_next = (clear_state_i || (lockout_duration_i == '0)) ? ST_IDLE : ST_LOCKOUT;
            ST_LOCKOUT: if (clear_state_i || w_lock_done) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_exp_res_nxt = (w_next == ST_ACK) && (r_src == EXPECTED);
        w_pre_res_nxt = (w_next == ST_ACK) && (r_src == PREEMPTIVE);
`ifdef CLKS_ALOT_DRIFT_CANCEL_EN
        if (w_next == ST_CANCEL) begin
            w_exp_res_nxt = 1'b1;
            w_pre_res_nxt = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_ptr            <= EXPECTED;
            r_src            <= EXPECTED;
            r_dir            <= DRIFT_DIR_A;
            r_adjust_req     <= 1'b0;
            r_expected_res   <= 1'b0;
            r_preemptive_res <= 1'b0;
            r_busy           <= 1'b0;
            r_clr_pend       <= 1'b0;
            r_count          <= '0;
        end else begin
            r_state          <= w_next;
            r_adjust_req     <= (w_next == ST_ISSUE);
            r_busy           <= (w_next != ST_IDLE);
            r_expected_res   <= w_exp_res_nxt;
            r_preemptive_res <= w_pre_res_nxt;
            r_clr_pend       <= (r_state == ST_ISSUE) && w_clr_issue && !adjust_res_i;
            if ((r_state == ST_IDLE) && (w_next == ST_ISSUE)) begin
                r_src <= w_grant_src;
                r_dir <= (w_grant_src == EXPECTED) ? drift_direction_e'(expected_dir_i)
                                                   : drift_direction_e'(preemptive_dir_i);
            end
            if (w_soft_clear) begin
                r_count <= '0;
                r_ptr   <= EXPECTED;
            end else if (r_state == ST_ACK) begin
                if (r_count != '1) r_count <= r_count + COUNT_WIDTH'(1);
                r_ptr <= (r_src == EXPECTED) ? PREEMPTIVE : EXPECTED;
            end
        end
    end

`ifdef CLKS_ALOT_DRIFT_CANCEL_EN
    logic r_cancel;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cancel <= 1'b0;
        else        r_cancel <= (w_next == ST_CANCEL);
    end
    assign cancel_o = r_cancel;
`else
    assign cancel_o = 1'b0;
`endif

    drift_lockout_timer u_lockout_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_lock_load),
        .i_abort    (w_lock_abort),
        .i_load_val (lockout_duration_i),
        .o_done     (w_lock_done)
    );

    assign adjust_req_o     = r_adjust_req;
    assign adjust_dir_o     = r_dir;
    assign adjust_src_o     = r_src;
    assign expected_res_o   = r_expected_res;
    assign preemptive_res_o = r_preemptive_res;
    assign busy_o           = r_busy;
    assign adjust_count_o   = r_count;

endmodule

// File: tb/tb_drift_request_scheduler.sv
// Scoreboard bench for drift_request_scheduler: stimulus pushes expected handshake events with
// their cycle numbers, a monitor pops and compares each event the DUT presents.
module tb_drift_request_scheduler;
    import drift_request_scheduler_pkg::*;

    localparam int CW    = 16;
    localparam int K_ADJ = 0;
    localparam int K_EXP = 1;
    localparam int K_PRE = 2;
    localparam int K_CAN = 3;

    typedef struct {
        int   kind;
        logic src;
        logic dir;
        int   cyc;
    } ev_t;

    logic clk, rst_n, scheduler_en_i, clear_state_i;
    logic [DRIFT_COUNTER_WIDTH-1:0] lockout_duration_i;
    logic expected_req_i, expected_res_o, expected_dir_i;
    logic preemptive_req_i, preemptive_res_o, preemptive_dir_i;
    logic adjust_req_o, adjust_res_i, adjust_dir_o, adjust_src_o, busy_o, cancel_o;
    logic [CW-1:0] adjust_count_o;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  gen_lat = 0;
    int  t;

    drift_request_scheduler #(.COUNT_WIDTH(CW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .scheduler_en_i     (scheduler_en_i),
        .clear_state_i      (clear_state_i),
        .lockout_duration_i (lockout_duration_i),
        .expected_req_i     (expected_req_i),
        .expected_res_o     (expected_res_o),
        .expected_dir_i     (expected_dir_i),
        .preemptive_req_i   (preemptive_req_i),
        .preemptive_res_o   (preemptive_res_o),
        .preemptive_dir_i   (preemptive_dir_i),
        .adjust_req_o       (adjust_req_o),
        .adjust_res_i       (adjust_res_i),
        .adjust_dir_o       (adjust_dir_o),
        .adjust_src_o       (adjust_src_o),
        .busy_o             (busy_o),
        .cancel_o           (cancel_o),
        .adjust_count_o     (adjust_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int kind, input logic src, input logic dir, input int c);
        ev_t e;
        e.kind = kind; e.src = src; e.dir = dir; e.cyc = c;
        exp_q.push_back(e);
    endtask

    // Advance to cycle c at a falling edge; the requesters drop req once they see res.
    task automatic at(input int c);
        while (cyc < c) begin
            @(negedge clk);
            if (expected_res_o)   expected_req_i   = 1'b0;
            if (preemptive_res_o) preemptive_req_i = 1'b0;
        end
    endtask

    task automatic see(input int kind, input logic src, input logic dir);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d src %0d dir %0d at cycle %0d, want none",
                     kind, src, dir, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.src !== src || e.dir !== dir || e.cyc != cyc) begin
                errors++;
                $display("FAIL event: got kind %0d src %0d dir %0d cycle %0d, want kind %0d src %0d dir %0d cycle %0d",
                         kind, src, dir, cyc, e.kind, e.src, e.dir, e.cyc);
            end
        end
    endtask

    // Monitor
    initial begin
        logic prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (adjust_req_o && !prev_req) see(K_ADJ, adjust_src_o, adjust_dir_o);
            if (expected_res_o)   see(K_EXP, 1'b0, 1'b0);
            if (preemptive_res_o) see(K_PRE, 1'b0, 1'b0);
            if (cancel_o)         see(K_CAN, 1'b0, 1'b0);
            prev_req = adjust_req_o;
        end
    end

    // Clock generator model: acks gen_lat cycles after seeing adjust_req_o.
    initial begin
        adjust_res_i = 1'b0;
        forever begin
            @(negedge clk);
            if (adjust_req_o) begin
                repeat (gen_lat) @(negedge clk);
                adjust_res_i = 1'b1;
                @(negedge clk);
                adjust_res_i = 1'b0;
            end
        end
    end

    initial begin
        rst_n = 1'b0; scheduler_en_i = 1'b1; clear_state_i = 1'b0; lockout_duration_i = '0;
        expected_req_i = 1'b0; expected_dir_i = 1'b0;
        preemptive_req_i = 1'b0; preemptive_dir_i = 1'b0;
        at(3);
        chk("reset_outputs", {adjust_req_o, busy_o, expected_res_o, preemptive_res_o, cancel_o,
                              adjust_dir_o, adjust_src_o, adjust_count_o}, 64'd0);
        rst_n = 1'b1;
        at(5);

        // Single expected request, L=4, generator ack two cycles after adjust_req_o
        lockout_duration_i = 8'd4; gen_lat = 2; t = cyc;
        expected_dir_i = 1'b0; expected_req_i = 1'b1;
        push(K_ADJ, 1'b0, 1'b0, t + 1);
        push(K_EXP, 1'b0, 1'b0, t + 4);
        at(t + 3); chk("s1_req_held", adjust_req_o, 1);
        at(t + 8); chk("s1_busy_lockout", busy_o, 1);
        at(t + 9); chk("s1_idle", busy_o, 0); chk("s1_count", adjust_count_o, 1);
        at(t + 10); clear_state_i = 1'b1;
        at(t + 11); clear_state_i = 1'b0; chk("idle_clear_count", adjust_count_o, 0);

        // Both pending, same direction, L=0, immediate ack; expected re-requests
        lockout_duration_i = 8'd0; gen_lat = 0; t = cyc;
        expected_dir_i = 1'b1; preemptive_dir_i = 1'b1;
        expected_req_i = 1'b1; preemptive_req_i = 1'b1;
        push(K_ADJ, 1'b0, 1'b1, t + 1); push(K_EXP, 1'b0, 1'b0, t + 2);
        push(K_ADJ, 1'b1, 1'b1, t + 4); push(K_PRE, 1'b0, 1'b0, t + 5);
        push(K_ADJ, 1'b0, 1'b1, t + 7); push(K_EXP, 1'b0, 1'b0, t + 8);
        at(t + 3); expected_req_i = 1'b1;
        at(t + 9); chk("s2_idle", busy_o, 0); chk("s2_count", adjust_count_o, 3);

        // Preemptive arrives during a 10-cycle lockout; lockout input changed mid-lockout
        lockout_duration_i = 8'd10; t = cyc;
        expected_dir_i = 1'b0; expected_req_i = 1'b1;
        push(K_ADJ, 1'b0, 1'b0, t + 1);  push(K_EXP, 1'b0, 1'b0, t + 2);
        push(K_ADJ, 1'b1, 1'b1, t + 14); push(K_PRE, 1'b0, 1'b0, t + 15);
        at(t + 4); preemptive_dir_i = 1'b1; preemptive_req_i = 1'b1;
        at(t + 5); lockout_duration_i = 8'd3;
        at(t + 12); chk("s3_busy_lockout", busy_o, 1);
        at(t + 13); chk("s3_idle_gap", busy_o, 0); chk("s3_no_req_yet", adjust_req_o, 0);
        at(t + 18); chk("s3_busy_lockout2", busy_o, 1);
        at(t + 19); chk("s3_idle", busy_o, 0); chk("s3_count", adjust_count_o, 5);

        // Clear pulsed during ISSUE, ack five cycles later
        clear_state_i = 1'b1;
        at(cyc + 1); clear_state_i = 1'b0; chk("pre_s4_count", adjust_count_o, 0);
        lockout_duration_i = 8'd0; gen_lat = 5; t = cyc;
        expected_dir_i = 1'b1; expected_req_i = 1'b1;
        push(K_ADJ, 1'b0, 1'b1, t + 1);
        push(K_ADJ, 1'b0, 1'b1, t + 8); push(K_EXP, 1'b0, 1'b0, t + 14);
        at(t + 2); clear_state_i = 1'b1;
        at(t + 3); clear_state_i = 1'b0;
        at(t + 6); chk("s4_req_held", adjust_req_o, 1);
        at(t + 7); chk("s4_req_dropped", adjust_req_o, 0); chk("s4_idle", busy_o, 0);
        chk("s4_count_after_clear", adjust_count_o, 0);
        at(t + 15); chk("s4_count", adjust_count_o, 1);

        // Opposite directions, held off by scheduler_en_i for three cycles
        gen_lat = 0; scheduler_en_i = 1'b0; t = cyc;
        expected_dir_i = 1'b0; preemptive_dir_i = 1'b1;
        expected_req_i = 1'b1; preemptive_req_i = 1'b1;
`ifdef CLKS_ALOT_DRIFT_CANCEL_EN
        push(K_EXP, 1'b0, 1'b0, t + 4); push(K_PRE, 1'b0, 1'b0, t + 4); push(K_CAN, 1'b0, 1'b0, t + 4);
        at(t + 3); chk("s5_disabled_idle", busy_o, 0); scheduler_en_i = 1'b1;
        at(t + 5); chk("s5_count", adjust_count_o, 1); chk("s5_idle", busy_o, 0);
        chk("s5_no_req", adjust_req_o, 0);
`else
        push(K_ADJ, 1'b1, 1'b1, t + 4); push(K_PRE, 1'b0, 1'b0, t + 5);
        push(K_ADJ, 1'b0, 1'b0, t + 7); push(K_EXP, 1'b0, 1'b0, t + 8);
        at(t + 3); chk("s5_disabled_idle", busy_o, 0); scheduler_en_i = 1'b1;
        at(t + 9); chk("s5_count", adjust_count_o, 3); chk("s5_idle", busy_o, 0);
`endif

        // Async reset during ISSUE, then a simultaneous pair
        gen_lat = 20; t = cyc;
        preemptive_dir_i = 1'b1; preemptive_req_i = 1'b1;
        push(K_ADJ, 1'b1, 1'b1, t + 1);
        at(t + 3); chk("s6_in_issue", adjust_req_o, 1);
        rst_n = 1'b0; preemptive_req_i = 1'b0;
        #1;
        chk("s6_async_reset", {adjust_req_o, busy_o, expected_res_o, preemptive_res_o, cancel_o,
                               adjust_dir_o, adjust_src_o, adjust_count_o}, 64'd0);
        at(t + 5); rst_n = 1'b1;
        at(t + 30); gen_lat = 0; t = cyc;
        expected_dir_i = 1'b0; preemptive_dir_i = 1'b0;
        expected_req_i = 1'b1; preemptive_req_i = 1'b1;
        push(K_ADJ, 1'b0, 1'b0, t + 1); push(K_EXP, 1'b0, 1'b0, t + 2);
        push(K_ADJ, 1'b1, 1'b0, t + 4); push(K_PRE, 1'b0, 1'b0, t + 5);
        at(t + 6); chk("s6_count", adjust_count_o, 2); chk("s6_idle", busy_o, 0);

        at(cyc + 3);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
